// File: rtl/fma_stream_feeder.sv
// Memory-mapped operand feeder for a pipelined arithmetic unit: operand registers, valid/ready
// launch with result credits, a circular result FIFO, status and cycle profiling counters.
module fma_stream_feeder #(
    parameter int              XLEN      = 32,
    parameter int              NUM_OPS   = 3,
    parameter int              RES_DEPTH = 4,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'hC400_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [XLEN-1:0]         addr_i,
    input  logic [XLEN-1:0]         data_i,
    output logic                    data_ready_o,
    output logic [XLEN-1:0]         data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [NUM_OPS*XLEN-1:0] operands_o,
    input  logic                    result_valid_i,
    input  logic [XLEN-1:0]         result_data_i
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [5:0] IDX_CTRL   = 6'h10;
    localparam logic [5:0] IDX_STATUS = 6'h11;
    localparam logic [5:0] IDX_RESULT = 6'h12;
    localparam logic [5:0] IDX_CNTIN  = 6'h13;
    localparam logic [5:0] IDX_CNTCLC = 6'h14;
    localparam logic [5:0] IDX_CNTWT  = 6'h15;

    logic [XLEN-1:0]         offset;
    logic                    inWindow, access, aligned, wrAccess, rdAccess;
    logic [5:0]              wordIdx;
    logic                    opHit, opWrite, ctrlWrite, resultRead;
    logic                    goReq, clearReq, autoGo;

    logic [XLEN-1:0]         ops_q [NUM_OPS];
    logic [XLEN-1:0]         ops_d [NUM_OPS];
    logic [NUM_OPS*XLEN-1:0] operands_q, operands_d, opsPacked;
    logic                    valid_q, valid_d, pending_q, pending_d;
    logic                    autoMode_q, autoMode_d, ovf_q, ovf_d;
    logic [7:0]              outstanding_q, outstanding_d, outTmp;
    logic [8:0]              creditUsed;
    logic                    launchReq, canPresent, fire, transfer;

    logic [XLEN-1:0]         mem_q [RES_DEPTH];
    logic [PW-1:0]           wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    fifoFull, push, pushOk, pop;

    logic [31:0]             inputCnt_q, inputCnt_d, calcCnt_q, calcCnt_d, waitCnt_q, waitCnt_d;
    logic                    dataReady_q;
    logic [XLEN-1:0]         dataOut_q, dataOut_d, rdata;
    logic [31:0]             statusWord;

    assign offset     = addr_i - BASE_ADDR;
    assign inWindow   = (offset[XLEN-1:8] == '0);
    assign access     = en_i && inWindow;
    assign aligned    = (offset[1:0] == 2'b00);
    assign wordIdx    = offset[7:2];
    assign wrAccess   = access && we_i && aligned;
    assign rdAccess   = access && !we_i && aligned;
    assign opHit      = (wordIdx < 6'(NUM_OPS));
    assign opWrite    = wrAccess && opHit;
    assign ctrlWrite  = wrAccess && (wordIdx == IDX_CTRL);
    assign resultRead = rdAccess && (wordIdx == IDX_RESULT);
    assign goReq      = ctrlWrite && data_i[0];
    assign clearReq   = ctrlWrite && data_i[1];
    assign autoGo     = opWrite && autoMode_q && (wordIdx == 6'(NUM_OPS - 1));

    assign fifoFull   = (count_q == CW'(RES_DEPTH));
    assign transfer   = valid_q && ready_i;
    // A bundle still sitting on valid_o already holds a result slot, so it counts against credit.
    assign creditUsed = {1'b0, outstanding_q} + 9'(count_q) + 9'(valid_q);

    assign statusWord = {8'd0, outstanding_q, 8'(count_q), 3'd0, autoMode_q, ovf_q,
                         fifoFull, (count_q != '0),
                         (pending_q || valid_q || (outstanding_q != 8'd0))};

    always_comb begin
        ops_d = ops_q;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (opWrite && (wordIdx == 6'(k))) ops_d[k] = data_i;
        end
        opsPacked = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            opsPacked[k*XLEN +: XLEN] = ops_d[k];
        end

        launchReq  = goReq || autoGo || pending_q;
        canPresent = !valid_q || ready_i;
        fire       = launchReq && canPresent && (creditUsed < 9'(RES_DEPTH)) && !clearReq;

        valid_d    = clearReq ? 1'b0 : (fire ? 1'b1 : (transfer ? 1'b0 : valid_q));
        operands_d = fire ? opsPacked : operands_q;
        pending_d  = !clearReq && launchReq && !fire;
        autoMode_d = ctrlWrite ? data_i[2] : autoMode_q;

        outTmp = outstanding_q + 8'(transfer);
        if (result_valid_i && (outTmp != 8'd0)) outTmp = outTmp - 8'd1;
        outstanding_d = clearReq ? 8'd0 : outTmp;

        // Full FIFO still accepts a push when the head leaves on the same cycle.
        push   = result_valid_i && !clearReq;
        pop    = resultRead && (count_q != '0);
        pushOk = push && (!fifoFull || pop);
        ovf_d  = clearReq ? 1'b0 : (ovf_q || (push && !pushOk));

        wrPtr_d = wrPtr_q + PW'(pushOk);
        rdPtr_d = rdPtr_q + PW'(pop);
        count_d = count_q + CW'(pushOk) - CW'(pop);
        if (clearReq) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end

        inputCnt_d = clearReq ? 32'd0 : inputCnt_q + 32'(opWrite);
        calcCnt_d  = clearReq ? 32'd0 : calcCnt_q + 32'(outstanding_q != 8'd0);
        waitCnt_d  = clearReq ? 32'd0 : waitCnt_q + 32'(count_q != '0);

        rdata = '0;
        if (opHit) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (wordIdx == 6'(k)) rdata = ops_q[k];
            end
        end
        case (wordIdx)
            IDX_STATUS: rdata = XLEN'(statusWord);
            IDX_RESULT: rdata = (count_q != '0) ? mem_q[rdPtr_q] : '0;
            IDX_CNTIN:  rdata = XLEN'(inputCnt_q);
            IDX_CNTCLC: rdata = XLEN'(calcCnt_q);
            IDX_CNTWT:  rdata = XLEN'(waitCnt_q);
            default:    ;
        endcase
        dataOut_d = rdAccess ? rdata : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_OPS; k++) ops_q[k] <= '0;
            for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
            operands_q    <= '0;
            valid_q       <= 1'b0;
            pending_q     <= 1'b0;
            autoMode_q    <= 1'b0;
            ovf_q         <= 1'b0;
            outstanding_q <= 8'd0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            inputCnt_q    <= 32'd0;
            calcCnt_q     <= 32'd0;
            waitCnt_q     <= 32'd0;
            dataReady_q   <= 1'b0;
            dataOut_q     <= '0;
        end else begin
            ops_q         <= ops_d;
            if (pushOk) mem_q[wrPtr_q] <= result_data_i;
            operands_q    <= operands_d;
            valid_q       <= valid_d;
            pending_q     <= pending_d;
            autoMode_q    <= autoMode_d;
            ovf_q         <= ovf_d;
            outstanding_q <= outstanding_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            inputCnt_q    <= inputCnt_d;
            calcCnt_q     <= calcCnt_d;
            waitCnt_q     <= waitCnt_d;
            dataReady_q   <= access;
            dataOut_q     <= dataOut_d;
        end
    end

    assign data_ready_o = dataReady_q;
    assign data_o       = dataOut_q;
    assign valid_o      = valid_q;
    assign operands_o   = operands_q;

endmodule

// File: tb/tb_fma_stream_feeder.sv
// Scoreboarded bench for fma_stream_feeder: directed bus/result stimulus, expected bus read data
// and launched operand bundles queued up front and checked by an independent monitor.
module tb_fma_stream_feeder;

    localparam int          XLEN      = 32;
    localparam int          NUM_OPS   = 3;
    localparam int          RES_DEPTH = 4;
    localparam logic [31:0] BASE      = 32'hC400_0000;

    localparam logic [31:0] OFF_CTRL = 32'h40, OFF_STATUS = 32'h44, OFF_RESULT = 32'h48;
    localparam logic [31:0] OFF_CIN  = 32'h4C, OFF_CCALC  = 32'h50, OFF_CWAIT  = 32'h54;

    logic                    clk, rst;
    logic                    en, we;
    logic [XLEN-1:0]         addr, wdata;
    logic                    dataReady;
    logic [XLEN-1:0]         rdata;
    logic                    valid, ready;
    logic [NUM_OPS*XLEN-1:0] operands;
    logic                    resValid;
    logic [XLEN-1:0]         resData;

    typedef struct {
        bit          check;
        logic [31:0] expVal;
        string       name;
    } busExp_t;

    busExp_t     busQ[$];
    logic [95:0] bundleQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;

    fma_stream_feeder #(
        .XLEN(XLEN), .NUM_OPS(NUM_OPS), .RES_DEPTH(RES_DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_ready_o(dataReady), .data_o(rdata), .valid_o(valid), .ready_i(ready),
        .operands_o(operands), .result_valid_i(resValid), .result_data_i(resData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bus access held for exactly one clock; acknowledged accesses queue their expectation.
    task automatic applyStimulus(input logic isWrite, input logic [31:0] off, input logic [31:0] value,
                                 input bit ackExpected, input bit check, input logic [31:0] expVal,
                                 input string name);
        busExp_t e;
        en    = 1'b1;
        we    = isWrite;
        addr  = BASE + off;
        wdata = value;
        if (ackExpected) begin
            e.check  = check;
            e.expVal = expVal;
            e.name   = name;
            busQ.push_back(e);
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        we = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] off, input logic [31:0] value);
        applyStimulus(1'b1, off, value, 1'b1, 1'b0, 32'd0, "write");
    endtask

    task automatic busRead(input logic [31:0] off, input logic [31:0] expVal, input string name);
        applyStimulus(1'b0, off, 32'd0, 1'b1, 1'b1, expVal, name);
    endtask

    task automatic pulseResult(input logic [31:0] value);
        resValid = 1'b1;
        resData  = value;
        @(posedge clk);
        #1;
        resValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] bundle(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    // Monitor: pops an expectation for every bus acknowledge and every completed bundle transfer.
    always @(negedge clk) begin
        busExp_t     e;
        logic [95:0] b;
        if (!rst) begin
            if (dataReady) begin
                if (busQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected ack: got data 0x%0h, required no acknowledge", rdata);
                end else begin
                    e = busQ.pop_front();
                    if (e.check) checkOutput(e.name, 96'(rdata), 96'(e.expVal));
                end
            end
            if (valid && ready) begin
                if (bundleQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected transfer: got operands 0x%0h, required no transfer", operands);
                end else begin
                    b = bundleQ.pop_front();
                    checkOutput("bundle operands", operands, b);
                end
            end
        end
    end

    initial begin
        #300000;
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        ready = 1'b1; resValid = 1'b0; resData = '0;
        idle(3);
        checkOutput("reset data_ready_o", 96'(dataReady), 96'd0);
        checkOutput("reset data_o", 96'(rdata), 96'd0);
        checkOutput("reset valid_o", 96'(valid), 96'd0);
        checkOutput("reset operands_o", operands, 96'd0);
        rst = 1'b0;
        idle(1);

        // Basic launch with explicit GO
        busWrite(32'h0, 32'h3F80_0000);
        busWrite(32'h4, 32'h4000_0000);
        busWrite(32'h8, 32'h4040_0000);
        bundleQ.push_back(bundle(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000));
        busWrite(OFF_CTRL, 32'h1);
        checkOutput("launch valid_o high", 96'(valid), 96'd1);
        idle(1);
        checkOutput("valid_o one cycle", 96'(valid), 96'd0);
        pulseResult(32'h40A0_0000);
        busRead(OFF_STATUS, 32'h0000_0102, "status after result");
        busRead(OFF_RESULT, 32'h40A0_0000, "result pop");
        busRead(OFF_STATUS, 32'h0000_0000, "status after pop");
        busRead(OFF_CCALC, 32'd1, "calc counter");
        busRead(OFF_CWAIT, 32'd2, "wait counter");
        busRead(32'h4, 32'h4000_0000, "operand1 readback");
        applyStimulus(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, "outside");
        checkOutput("no ack outside window", 96'(dataReady), 96'd0);
        busRead(32'h0, 32'h3F80_0000, "operand0 untouched");

        // AUTO mode: CLEAR and set AUTO in one CTRL write
        busWrite(OFF_CTRL, 32'h6);
        for (int i = 0; i < 3; i++) begin
            busWrite(32'h0, 32'h10 + i);
            busWrite(32'h4, 32'h20 + i);
            bundleQ.push_back(bundle(32'h10 + i, 32'h20 + i, 32'h30 + i));
            busWrite(32'h8, 32'h30 + i);
        end
        idle(2);
        for (int i = 1; i <= 3; i++) pulseResult(i);
        for (int i = 1; i <= 3; i++) busRead(OFF_RESULT, i, "auto result order");
        busRead(OFF_CIN, 32'd9, "input counter");
        busRead(OFF_STATUS, 32'h0000_0010, "status auto idle");

        // Backpressure: AUTO off, ready held low
        busWrite(OFF_CTRL, 32'h2);
        ready = 1'b0;
        busWrite(32'h0, 32'hD0D0_0001);
        busWrite(32'h4, 32'hE0E0_0002);
        busWrite(32'h8, 32'hF0F0_0003);
        bundleQ.push_back(bundle(32'hD0D0_0001, 32'hE0E0_0002, 32'hF0F0_0003));
        busWrite(OFF_CTRL, 32'h1);
        busWrite(32'h0, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            checkOutput("held valid_o", 96'(valid), 96'd1);
            checkOutput("held operands_o", operands, bundle(32'hD0D0_0001, 32'hE0E0_0002, 32'hF0F0_0003));
            idle(1);
        end
        ready = 1'b1;
        idle(1);
        checkOutput("valid_o after transfer", 96'(valid), 96'd0);
        busRead(OFF_STATUS, 32'h0001_0001, "outstanding after transfer");
        busWrite(OFF_CTRL, 32'h2);

        // Credit exhaustion: four launches, fifth stays pending
        for (int i = 0; i < 4; i++) begin
            bundleQ.push_back(bundle(32'h1234_5678, 32'hE0E0_0002, 32'hF0F0_0003));
            busWrite(OFF_CTRL, 32'h1);
        end
        busWrite(OFF_CTRL, 32'h1);
        idle(2);
        checkOutput("pending no valid_o", 96'(valid), 96'd0);
        busRead(OFF_STATUS, 32'h0004_0001, "status credit full");
        pulseResult(32'hAA);
        idle(2);
        checkOutput("still pending after push", 96'(valid), 96'd0);
        busRead(OFF_STATUS, 32'h0003_0103, "status push no credit");
        bundleQ.push_back(bundle(32'h1234_5678, 32'hE0E0_0002, 32'hF0F0_0003));
        busRead(OFF_RESULT, 32'hAA, "credit result pop");
        checkOutput("no launch on pop edge", 96'(valid), 96'd0);
        idle(1);
        checkOutput("pending launch fires", 96'(valid), 96'd1);
        busWrite(OFF_CTRL, 32'h2);

        // Overflow and CLEAR
        for (int i = 0; i < 5; i++) pulseResult(32'h100 + i);
        busRead(OFF_STATUS, 32'h0000_040E, "status overflow");
        for (int i = 0; i < 4; i++) busRead(OFF_RESULT, 32'h100 + i, "overflow contents");
        busRead(OFF_RESULT, 32'h0, "fifth result dropped");
        busRead(OFF_STATUS, 32'h0000_0008, "ovf sticky");
        busWrite(OFF_CTRL, 32'h2);
        busRead(OFF_STATUS, 32'h0, "status after clear");
        busRead(OFF_CIN, 32'h0, "input counter cleared");
        busRead(OFF_CCALC, 32'h0, "calc counter cleared");
        busRead(OFF_CWAIT, 32'h0, "wait counter cleared");

        // Simultaneous push and pop at count 2
        pulseResult(32'h200);
        pulseResult(32'h201);
        resValid = 1'b1;
        resData  = 32'h202;
        busRead(OFF_RESULT, 32'h200, "simultaneous pop head");
        resValid = 1'b0;
        busRead(OFF_STATUS, 32'h0000_0202, "count after push+pop");
        busRead(OFF_RESULT, 32'h201, "second entry");
        busRead(OFF_RESULT, 32'h202, "third entry");
        busRead(OFF_RESULT, 32'h0, "empty read");
        busRead(OFF_STATUS, 32'h0, "status empty");

        // Asynchronous reset while a bundle is presented
        ready = 1'b0;
        busWrite(OFF_CTRL, 32'h1);
        checkOutput("valid before reset", 96'(valid), 96'd1);
        #6;
        rst = 1'b1;
        #1;
        checkOutput("async reset valid_o", 96'(valid), 96'd0);
        checkOutput("async reset operands_o", operands, 96'd0);
        idle(1);
        rst = 1'b0;
        ready = 1'b1;
        idle(2);
        checkOutput("bus expectations drained", 96'(busQ.size()), 96'd0);
        checkOutput("bundle expectations drained", 96'(bundleQ.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
